// File: rtl/gpu_stencil_sched_pkg.sv
// Shared types and helpers for the stencil-cache scheduler: widths, fill state
// encoding and the cache bank-select function.
package gpu_stencil_pkg;

   localparam int unsigned ST_ADDR_W = 15;
   localparam int unsigned ST_CNT_W  = 15;
   localparam int unsigned ST_DATA_W = 16;
   localparam int unsigned ST_BANK_W = 3;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_RUN,
      FILL_DONE
   } fill_state_e;

   // Bank select uses only address bits [7:6] and [0].
   function automatic logic [ST_BANK_W-1:0] st_bank(input logic [7:0] addr);
      return {addr[7:6], addr[0]};
   endfunction

endpackage

// File: rtl/gpu_stencil_sched_if.sv
// Stencil cache port bundle: the scheduler drives requests (master), the cache
// returns read data and its error flag (slave).
interface gpu_stencil_sched_if #(
   parameter int unsigned ADDR_W = 15
);
   import gpu_stencil_pkg::*;

   logic                 rd_req;
   logic [ADDR_W-1:0]    rd_addr;
   logic                 wr_req;
   logic [ADDR_W-1:0]    wr_addr;
   logic [ST_DATA_W-1:0] wr_mask;
   logic [ST_DATA_W-1:0] wr_value;
   logic [ST_DATA_W-1:0] rd_value;
   logic                 error;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_mask, wr_value,
      input  rd_value, error
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_mask, wr_value,
      output rd_value, error
   );
endinterface

// File: rtl/gpu_stencil_sched_fill_fsm.sv
// Bulk fill engine: walks a word range issuing one masked write per granted
// cycle, then pulses done for one cycle.
module gpu_stencil_fill_fsm
   import gpu_stencil_pkg::*;
#(
   parameter int unsigned ADDR_W = ST_ADDR_W,
   parameter int unsigned CNT_W  = ST_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [CNT_W-1:0]     count_i,
   input  logic [ST_DATA_W-1:0] mask_i,
   input  logic [ST_DATA_W-1:0] value_i,
   input  logic                 grant_i,
   output logic                 req_o,
   output logic [ADDR_W-1:0]    addr_o,
   output logic [ST_DATA_W-1:0] mask_o,
   output logic [ST_DATA_W-1:0] value_o,
   output logic                 busy_o,
   output logic                 done_o
);

   fill_state_e          state_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [CNT_W-1:0]     count_q;
   logic [ST_DATA_W-1:0] mask_q;
   logic [ST_DATA_W-1:0] value_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FILL_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         mask_q  <= '0;
         value_q <= '0;
      end else begin
         case (state_q)
            FILL_IDLE: begin
               if (start_i) begin
                  addr_q  <= addr_i;
                  count_q <= count_i;
                  mask_q  <= mask_i;
                  value_q <= value_i;
                  state_q <= (count_i == '0) ? FILL_DONE : FILL_RUN;
               end
            end
            FILL_RUN: begin
               if (grant_i) begin
                  // Address wraps naturally at the top of the word space.
                  addr_q  <= addr_q + 1'b1;
                  count_q <= count_q - 1'b1;
                  if (count_q == CNT_W'(1)) begin
                     state_q <= FILL_DONE;
                  end
               end
            end
            FILL_DONE: state_q <= FILL_IDLE;
            default:   state_q <= FILL_IDLE;
         endcase
      end
   end

   assign req_o   = (state_q == FILL_RUN);
   assign addr_o  = addr_q;
   assign mask_o  = mask_q;
   assign value_o = value_q;
   assign busy_o  = (state_q != FILL_IDLE);
   assign done_o  = (state_q == FILL_DONE);

endmodule

// File: rtl/gpu_stencil_sched.sv
// Stencil cache scheduler: arbitrates pixel and fill writes so no bank is written
// on consecutive cycles, and holds reads behind same-cycle same-address writes.
module gpu_stencil_sched
   import gpu_stencil_pkg::*;
#(
   parameter int unsigned ADDR_W = ST_ADDR_W,
   parameter int unsigned CNT_W  = ST_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 pix_wr_req_i,
   input  logic [ADDR_W-1:0]    pix_wr_addr_i,
   input  logic [ST_DATA_W-1:0] pix_wr_mask_i,
   input  logic [ST_DATA_W-1:0] pix_wr_value_i,
   output logic                 pix_wr_ack_o,
   input  logic                 pix_rd_req_i,
   input  logic [ADDR_W-1:0]    pix_rd_addr_i,
   output logic                 pix_rd_ack_o,
   output logic                 pix_rd_valid_o,
   output logic [ST_DATA_W-1:0] pix_rd_value_o,
   input  logic                 fill_start_i,
   input  logic [ADDR_W-1:0]    fill_addr_i,
   input  logic [CNT_W-1:0]     fill_count_i,
   input  logic [ST_DATA_W-1:0] fill_mask_i,
   input  logic [ST_DATA_W-1:0] fill_value_i,
   output logic                 fill_busy_o,
   output logic                 fill_done_o,
   gpu_stencil_sched_if.master  st,
   output logic                 sched_error_o
);

   logic                 fill_req;
   logic [ADDR_W-1:0]    fill_addr;
   logic [ST_DATA_W-1:0] fill_mask;
   logic [ST_DATA_W-1:0] fill_value;
   logic                 pix_gnt;
   logic                 fill_gnt;
   logic                 rd_gnt;
   logic                 pix_blk;
   logic                 fill_blk;

   logic [ST_BANK_W-1:0] last_bank_q, last_bank_d;
   logic                 last_valid_q, last_valid_d;
   logic                 rd_valid_q;
   logic                 err_q;

   gpu_stencil_fill_fsm #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_fill (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (fill_start_i),
      .addr_i  (fill_addr_i),
      .count_i (fill_count_i),
      .mask_i  (fill_mask_i),
      .value_i (fill_value_i),
      .grant_i (fill_gnt),
      .req_o   (fill_req),
      .addr_o  (fill_addr),
      .mask_o  (fill_mask),
      .value_o (fill_value),
      .busy_o  (fill_busy_o),
      .done_o  (fill_done_o)
   );

   always_comb begin
      pix_blk  = last_valid_q && (st_bank(pix_wr_addr_i[7:0]) == last_bank_q);
      fill_blk = last_valid_q && (st_bank(fill_addr[7:0]) == last_bank_q);
      pix_gnt  = !rst_i && pix_wr_req_i && !pix_blk;
      // A blocked pixel write lets a fill word to a free bank through.
      fill_gnt = !rst_i && fill_req && !fill_blk && !pix_gnt;

      st.wr_req   = pix_gnt || fill_gnt;
      st.wr_addr  = '0;
      st.wr_mask  = '0;
      st.wr_value = '0;
      if (pix_gnt) begin
         st.wr_addr  = pix_wr_addr_i;
         st.wr_mask  = pix_wr_mask_i;
         st.wr_value = pix_wr_value_i;
      end else if (fill_gnt) begin
         st.wr_addr  = fill_addr;
         st.wr_mask  = fill_mask;
         st.wr_value = fill_value;
      end

      // Same address cannot be written two cycles running, so a stall lasts one cycle.
      rd_gnt     = !rst_i && pix_rd_req_i && !(st.wr_req && (pix_rd_addr_i == st.wr_addr));
      st.rd_req  = rd_gnt;
      st.rd_addr = rd_gnt ? pix_rd_addr_i : '0;

      last_bank_d  = st_bank(st.wr_addr[7:0]);
      last_valid_d = st.wr_req;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_bank_q  <= '0;
         last_valid_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         last_bank_q  <= last_bank_d;
         last_valid_q <= last_valid_d;
         rd_valid_q   <= rd_gnt;
         err_q        <= err_q | st.error;
      end
   end

   assign pix_wr_ack_o   = pix_gnt;
   assign pix_rd_ack_o   = rd_gnt;
   assign pix_rd_valid_o = rd_valid_q;
   assign pix_rd_value_o = rd_valid_q ? st.rd_value : '0;
   assign sched_error_o  = err_q;

endmodule

// File: tb/tb_gpu_stencil_sched.sv
// Directed bench for gpu_stencil_sched with a behavioural banked cache that
// flags back-to-back writes to the same bank.
module tb_gpu_stencil_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_wr_req = 1'b0;
   logic [14:0] pix_wr_addr = '0;
   logic [15:0] pix_wr_mask = '0;
   logic [15:0] pix_wr_value = '0;
   logic        pix_wr_ack;
   logic        pix_rd_req = 1'b0;
   logic [14:0] pix_rd_addr = '0;
   logic        pix_rd_ack;
   logic        pix_rd_valid;
   logic [15:0] pix_rd_value;
   logic        fill_start = 1'b0;
   logic [14:0] fill_addr = '0;
   logic [14:0] fill_count = '0;
   logic [15:0] fill_mask = '0;
   logic [15:0] fill_value = '0;
   logic        fill_busy;
   logic        fill_done;
   logic        sched_error;

   int n_cmp = 0;
   int n_mis = 0;

   gpu_stencil_sched_if st_bus ();

   gpu_stencil_sched dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .pix_wr_req_i   (pix_wr_req),
      .pix_wr_addr_i  (pix_wr_addr),
      .pix_wr_mask_i  (pix_wr_mask),
      .pix_wr_value_i (pix_wr_value),
      .pix_wr_ack_o   (pix_wr_ack),
      .pix_rd_req_i   (pix_rd_req),
      .pix_rd_addr_i  (pix_rd_addr),
      .pix_rd_ack_o   (pix_rd_ack),
      .pix_rd_valid_o (pix_rd_valid),
      .pix_rd_value_o (pix_rd_value),
      .fill_start_i   (fill_start),
      .fill_addr_i    (fill_addr),
      .fill_count_i   (fill_count),
      .fill_mask_i    (fill_mask),
      .fill_value_i   (fill_value),
      .fill_busy_o    (fill_busy),
      .fill_done_o    (fill_done),
      .st             (st_bus),
      .sched_error_o  (sched_error)
   );

   always #5 clk = ~clk;

   // Cache model: 1-cycle read latency, masked write, error on same-bank back-to-back writes.
   logic [15:0] mem [0:32767];
   logic [15:0] cache_rd;
   logic        cache_err;
   logic        prev_wv;
   logic [2:0]  prev_wb;
   assign st_bus.rd_value = cache_rd;
   assign st_bus.error    = cache_err;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32768; i++) mem[i] <= '0;
         cache_rd  <= '0;
         cache_err <= 1'b0;
         prev_wv   <= 1'b0;
         prev_wb   <= '0;
      end else begin
         if (st_bus.wr_req)
            mem[st_bus.wr_addr] <= (mem[st_bus.wr_addr] & ~st_bus.wr_mask) |
                                   (st_bus.wr_value & st_bus.wr_mask);
         if (st_bus.rd_req) cache_rd <= mem[st_bus.rd_addr];
         if (st_bus.wr_req && prev_wv &&
             prev_wb == {st_bus.wr_addr[7:6], st_bus.wr_addr[0]})
            cache_err <= 1'b1;
         prev_wv <= st_bus.wr_req;
         prev_wb <= {st_bus.wr_addr[7:6], st_bus.wr_addr[0]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pw(input logic req, input logic [14:0] a, input logic [15:0] m,
                     input logic [15:0] v);
      pix_wr_req = req; pix_wr_addr = a; pix_wr_mask = m; pix_wr_value = v;
   endtask

   task automatic fs(input logic s, input logic [14:0] a, input logic [14:0] c,
                     input logic [15:0] m, input logic [15:0] v);
      fill_start = s; fill_addr = a; fill_count = c; fill_mask = m; fill_value = v;
   endtask

   initial begin
      // Reset: outputs quiet even with a pending pixel write
      cyc(); pw(1, 15'h0000, 16'hFFFF, 16'hAAAA); #1;
      chk("rst_wr_ack", pix_wr_ack, 0);
      chk("rst_wr_req", st_bus.wr_req, 0);
      chk("rst_busy", fill_busy, 0);
      chk("rst_done", fill_done, 0);
      chk("rst_rd_valid", pix_rd_valid, 0);
      chk("rst_serr", sched_error, 0);

      // 1: different banks back-to-back
      cyc(); rst = 0; #1;
      chk("t1_ack0", pix_wr_ack, 1);
      chk("t1_addr0", st_bus.wr_addr, 15'h0000);
      cyc(); pw(1, 15'h0040, 16'hFFFF, 16'h5555); #1;
      chk("t1_ack1", pix_wr_ack, 1);
      chk("t1_addr1", st_bus.wr_addr, 15'h0040);
      cyc(); pw(0, 15'h0000, 16'h0000, 16'h0000); #1;
      chk("t1_idle", st_bus.wr_req, 0);

      // 2: same bank, second write deferred a cycle
      cyc(); pw(1, 15'h0000, 16'hFFFF, 16'h1111); #1;
      chk("t2_ack0", pix_wr_ack, 1);
      cyc(); pw(1, 15'h0100, 16'hFFFF, 16'h2222); #1;
      chk("t2_blk_ack", pix_wr_ack, 0);
      chk("t2_gap", st_bus.wr_req, 0);
      cyc(); #1;
      chk("t2_ack1", pix_wr_ack, 1);
      chk("t2_addr1", st_bus.wr_addr, 15'h0100);

      // 3: masked write with a same-address read
      cyc(); pw(1, 15'h0005, 16'hFFFF, 16'hFFFF); #1;
      chk("t3_pre_ack", pix_wr_ack, 1);
      cyc(); pw(0, 15'h0000, 16'h0000, 16'h0000); #1;
      cyc(); pw(1, 15'h0005, 16'h00FF, 16'h1234); pix_rd_req = 1; pix_rd_addr = 15'h0005; #1;
      chk("t3_wr_ack", pix_wr_ack, 1);
      chk("t3_wr_mask", st_bus.wr_mask, 16'h00FF);
      chk("t3_wr_value", st_bus.wr_value, 16'h1234);
      chk("t3_rd_stall", pix_rd_ack, 0);
      cyc(); pw(0, 15'h0000, 16'h0000, 16'h0000); #1;
      chk("t3_rd_ack", pix_rd_ack, 1);
      chk("t3_st_rd_req", st_bus.rd_req, 1);
      cyc(); pix_rd_req = 0; #1;
      chk("t3_rd_valid", pix_rd_valid, 1);
      chk("t3_rd_value", pix_rd_value, 16'hFF34);
      cyc(); pix_rd_req = 1; pix_rd_addr = 15'h0000; #1;
      chk("t3_rd0_ack", pix_rd_ack, 1);
      cyc(); pix_rd_req = 0; #1;
      chk("t3_rd0_valid", pix_rd_valid, 1);
      chk("t3_rd0_value", pix_rd_value, 16'h1111);

      // 4: fill across the address wrap, with an ignored restart
      cyc(); fs(1, 15'h7FFE, 15'd4, 16'hFFFF, 16'hFFFF); #1;
      chk("t4_busy_start", fill_busy, 0);
      chk("t4_no_wr", st_bus.wr_req, 0);
      cyc(); fill_start = 0; #1;
      chk("t4_busy", fill_busy, 1);
      chk("t4_w0_req", st_bus.wr_req, 1);
      chk("t4_w0", st_bus.wr_addr, 15'h7FFE);
      chk("t4_w0_mask", st_bus.wr_mask, 16'hFFFF);
      cyc(); fs(1, 15'h1234, 15'd1, 16'h0000, 16'h0000); #1;
      chk("t4_w1", st_bus.wr_addr, 15'h7FFF);
      cyc(); fill_start = 0; #1;
      chk("t4_w2", st_bus.wr_addr, 15'h0000);
      cyc(); #1;
      chk("t4_w3", st_bus.wr_addr, 15'h0001);
      chk("t4_w3_req", st_bus.wr_req, 1);
      cyc(); #1;
      chk("t4_done", fill_done, 1);
      chk("t4_done_busy", fill_busy, 1);
      chk("t4_done_nowr", st_bus.wr_req, 0);
      cyc(); #1;
      chk("t4_done_off", fill_done, 0);
      chk("t4_busy_off", fill_busy, 0);

      // 5: zero-length fill
      cyc(); fs(1, 15'h0200, 15'd0, 16'hFFFF, 16'hFFFF); #1;
      chk("t5_done_early", fill_done, 0);
      cyc(); fill_start = 0; #1;
      chk("t5_done", fill_done, 1);
      chk("t5_nowr", st_bus.wr_req, 0);
      cyc(); #1;
      chk("t5_done_off", fill_done, 0);
      chk("t5_busy_off", fill_busy, 0);
      chk("t5_nowr2", st_bus.wr_req, 0);

      // 6: fill contending with bank-0 pixel writes
      cyc(); fs(1, 15'h0001, 15'd4, 16'h0F00, 16'h0000); pw(1, 15'h0100, 16'hFFFF, 16'h3333); #1;
      chk("t6_p0_ack", pix_wr_ack, 1);
      chk("t6_p0_addr", st_bus.wr_addr, 15'h0100);
      cyc(); fill_start = 0; pw(1, 15'h0200, 16'hFFFF, 16'h3333); #1;
      chk("t6_p1_blk", pix_wr_ack, 0);
      chk("t6_f1", st_bus.wr_addr, 15'h0001);
      cyc(); #1;
      chk("t6_p1_ack", pix_wr_ack, 1);
      chk("t6_p1_addr", st_bus.wr_addr, 15'h0200);
      cyc(); pw(1, 15'h0300, 16'hFFFF, 16'h3333); #1;
      chk("t6_p2_blk", pix_wr_ack, 0);
      chk("t6_gap", st_bus.wr_req, 0);
      cyc(); #1;
      chk("t6_p2_ack", pix_wr_ack, 1);
      chk("t6_p2_addr", st_bus.wr_addr, 15'h0300);
      cyc(); pw(0, 15'h0000, 16'h0000, 16'h0000); #1;
      chk("t6_f2_defer", st_bus.wr_req, 0);
      chk("t6_busy", fill_busy, 1);
      cyc(); #1;
      chk("t6_f2", st_bus.wr_addr, 15'h0002);
      cyc(); #1;
      chk("t6_f3", st_bus.wr_addr, 15'h0003);
      cyc(); #1;
      chk("t6_f4", st_bus.wr_addr, 15'h0004);
      cyc(); #1;
      chk("t6_done", fill_done, 1);
      cyc(); #1;
      chk("t6_busy_off", fill_busy, 0);
      chk("t6_serr", sched_error, 0);
      cyc(); pix_rd_req = 1; pix_rd_addr = 15'h0001; #1;
      chk("t6_rd_ack", pix_rd_ack, 1);
      cyc(); pix_rd_req = 0; #1;
      chk("t6_rd_value", pix_rd_value, 16'hF0FF);

      // Reset mid-fill aborts without a done pulse
      cyc(); fs(1, 15'h0010, 15'd8, 16'hFFFF, 16'h0000); #1;
      cyc(); fill_start = 0; #1;
      chk("tr_busy", fill_busy, 1);
      chk("tr_w0", st_bus.wr_addr, 15'h0010);
      cyc(); #1;
      chk("tr_w1", st_bus.wr_addr, 15'h0011);
      cyc(); rst = 1; #1;
      chk("tr_rst_nowr", st_bus.wr_req, 0);
      cyc(); rst = 0; #1;
      chk("tr_busy_off", fill_busy, 0);
      chk("tr_no_done", fill_done, 0);
      cyc(); #1;
      chk("tr_no_done2", fill_done, 0);
      chk("tr_idle", st_bus.wr_req, 0);
      chk("tr_serr", sched_error, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
